// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between MIPS fetch and memory stages
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  // fetch side
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              f_hold,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  // data side
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  // memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  // status
  output logic              bus_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              i_hit_q, i_hit_d;
  logic              d_hit_q, d_hit_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              bus_err_q, bus_err_d;

  logic              finish;
  logic              timeout;

  // Stalls follow the requests directly so the hazard unit sees them in the same cycle.
  assign i_stall   = i_req & ~i_hit_q;
  assign d_stall   = d_req & ~d_hit_q;

  // The memory bus is only driven from latched fields, and never from IDLE.
  assign mem_req   = (state_q != IDLE);
  assign mem_we    = mem_we_q & mem_req;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign bus_err   = bus_err_q;

  // A wait cycle ends on mem_ready, or on the last allowed cycle without it.
  assign finish  = mem_req & (mem_ready | (wait_cnt_q == LAST_WAIT));
  assign timeout = mem_req & ~mem_ready & (wait_cnt_q == LAST_WAIT);

  // Next-state: grant, wait/complete/abort, and hit bookkeeping.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    i_hit_d     = i_hit_q;
    d_hit_d     = d_hit_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    bus_err_d   = bus_err_q;

    // The M stage always advances once d_hit has been seen, so it lives one cycle.
    if (d_hit_q) begin
      d_hit_d = 1'b0;
    end
    // A fetch result is held until the F/D register actually takes it.
    if (i_hit_q && !d_stall && !f_hold) begin
      i_hit_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        if (d_stall) begin
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_we_d    = d_we;
          state_d     = D_WAIT;
        end else if (i_stall) begin
          mem_addr_d = i_addr;
          mem_we_d   = 1'b0;
          state_d    = I_WAIT;
        end
      end

      I_WAIT: begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        if (finish) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
          i_hit_d    = 1'b1;
          i_rdata_d  = mem_ready ? mem_rdata : '0;
        end
      end

      D_WAIT: begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        if (finish) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
          d_hit_d    = 1'b1;
          if (!mem_ready) begin
            d_rdata_d = '0;
          end else if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (timeout) begin
      bus_err_d = 1'b1;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      i_hit_q     <= 1'b0;
      d_hit_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      i_hit_q     <= i_hit_d;
      d_hit_q     <= d_hit_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      bus_err_q   <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        f_hold;
  logic [31:0] i_rdata;
  logic        i_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        bus_err;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .f_hold(f_hold),
    .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } mem_txn_t;

  mem_txn_t    exp_mem[$];
  logic [31:0] exp_d[$];
  logic [31:0] exp_i[$];

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 0;  // wait cycle in which mem_ready rises; 0 = never

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic push_mem(input logic [31:0] a, input logic we, input logic [31:0] wd);
    mem_txn_t t;
    t.addr = a; t.we = we; t.wdata = wd;
    exp_mem.push_back(t);
  endtask

  // Memory responder: counts wait cycles and answers in cycle mem_lat.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        wcnt++;
        mem_ready = (mem_lat != 0) && (wcnt == mem_lat);
        if (mem_ready)
          mem_rdata = (mem_addr == 32'h40) ? 32'h2008_0005 : (mem_addr ^ 32'h5A5A_0000);
        else
          mem_rdata = 32'hDEAD_BEEF;
      end else begin
        wcnt = 0;
        mem_ready = 1'b0;
      end
    end
  end

  // Monitor: pops expected transactions and deliveries as the DUT presents them.
  logic     prev_mem_req = 1'b0;
  logic     prev_d_stall = 1'b0;
  logic     prev_i_stall = 1'b0;
  mem_txn_t cur;
  always @(negedge clk) begin
    if (mem_req) begin
      if (!prev_mem_req) begin
        if (exp_mem.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL mem_unexpected: got addr 0x%0h, expected no transaction", mem_addr);
          cur.addr = mem_addr; cur.we = mem_we; cur.wdata = mem_wdata;
        end else begin
          cur = exp_mem.pop_front();
        end
      end
      chk("mem_addr", 64'(mem_addr), 64'(cur.addr));
      chk("mem_we", 64'(mem_we), 64'(cur.we));
      if (cur.we) chk("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
    end
    if (d_req && !d_stall && prev_d_stall) begin
      if (exp_d.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL d_unexpected: got d_rdata 0x%0h, expected no delivery", d_rdata);
      end else begin
        chk("d_rdata_sb", 64'(d_rdata), 64'(exp_d.pop_front()));
      end
    end
    if (i_req && !i_stall && prev_i_stall) begin
      if (exp_i.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL i_unexpected: got i_rdata 0x%0h, expected no delivery", i_rdata);
      end else begin
        chk("i_rdata_sb", 64'(i_rdata), 64'(exp_i.pop_front()));
      end
    end
    prev_mem_req = mem_req;
    prev_d_stall = d_stall;
    prev_i_stall = i_stall;
  end

  initial begin
    int st_cnt;
    int rq_cnt;
    reset_n = 1'b0; i_req = 1'b1; i_addr = 32'h0; f_hold = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;

    // Reset state
    nxt(); nxt();
    @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_i_rdata", 64'(i_rdata), 64'd0);
    chk("rst_d_rdata", 64'(d_rdata), 64'd0);
    chk("rst_bus_err", 64'(bus_err), 64'd0);
    chk("rst_i_stall", 64'(i_stall), 64'd1);
    nxt(); i_req = 1'b0;

    // Zero-wait fetch
    nxt(); reset_n = 1'b1; i_req = 1'b1; i_addr = 32'h40; mem_lat = 1;
    push_mem(32'h40, 1'b0, 32'h0); exp_i.push_back(32'h2008_0005);
    @(negedge clk); chk("zw_c0_stall", 64'(i_stall), 64'd1); chk("zw_c0_req", 64'(mem_req), 64'd0);
    nxt(); @(negedge clk); chk("zw_c1_stall", 64'(i_stall), 64'd1); chk("zw_c1_req", 64'(mem_req), 64'd1);
    nxt(); @(negedge clk); chk("zw_c2_stall", 64'(i_stall), 64'd0); chk("zw_c2_req", 64'(mem_req), 64'd0);
    chk("zw_c2_rdata", 64'(i_rdata), 64'h2008_0005);
    nxt(); i_req = 1'b0;
    @(negedge clk); chk("zw_c3_req", 64'(mem_req), 64'd0);

    // Priority: simultaneous load and fetch
    nxt(); i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    push_mem(32'h100, 1'b0, 32'h0); push_mem(32'h44, 1'b0, 32'h0);
    exp_d.push_back(32'h5A5A_0100); exp_i.push_back(32'h5A5A_0044);
    @(negedge clk); chk("pr_c0_dst", 64'(d_stall), 64'd1); chk("pr_c0_ist", 64'(i_stall), 64'd1);
    nxt(); @(negedge clk); chk("pr_c1_addr", 64'(mem_addr), 64'h100); chk("pr_c1_dst", 64'(d_stall), 64'd1);
    nxt(); @(negedge clk); chk("pr_c2_dst", 64'(d_stall), 64'd0); chk("pr_c2_ist", 64'(i_stall), 64'd1);
    chk("pr_c2_req", 64'(mem_req), 64'd0); chk("pr_c2_drd", 64'(d_rdata), 64'h5A5A_0100);
    nxt(); d_req = 1'b0;
    @(negedge clk); chk("pr_c3_req", 64'(mem_req), 64'd1); chk("pr_c3_addr", 64'(mem_addr), 64'h44);
    nxt(); @(negedge clk); chk("pr_c4_ist", 64'(i_stall), 64'd0); chk("pr_c4_ird", 64'(i_rdata), 64'h5A5A_0044);
    nxt(); i_req = 1'b0;

    // Store with 3 wait cycles
    nxt(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hCAFE_F00D; mem_lat = 3;
    push_mem(32'h200, 1'b1, 32'hCAFE_F00D); exp_d.push_back(32'h5A5A_0100);
    st_cnt = 0; rq_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) nxt();
      @(negedge clk);
      if (d_stall) st_cnt++;
      if (mem_req) rq_cnt++;
    end
    chk("st_stall_cycles", 64'(st_cnt), 64'd4);
    chk("st_req_cycles", 64'(rq_cnt), 64'd3);
    chk("st_drd_kept", 64'(d_rdata), 64'h5A5A_0100);
    nxt(); d_req = 1'b0; d_we = 1'b0;

    // Held fetch
    nxt(); i_req = 1'b1; i_addr = 32'h48; f_hold = 1'b1; mem_lat = 1;
    push_mem(32'h48, 1'b0, 32'h0); exp_i.push_back(32'h5A5A_0048);
    nxt(); nxt();
    for (int k = 2; k < 5; k++) begin
      if (k > 2) nxt();
      @(negedge clk);
      chk("hold_ist", 64'(i_stall), 64'd0); chk("hold_req", 64'(mem_req), 64'd0);
      chk("hold_ird", 64'(i_rdata), 64'h5A5A_0048);
    end
    nxt(); f_hold = 1'b0;
    @(negedge clk); chk("hold_c5_ist", 64'(i_stall), 64'd0);
    nxt(); i_addr = 32'h4C; push_mem(32'h4C, 1'b0, 32'h0); exp_i.push_back(32'h5A5A_004C);
    @(negedge clk); chk("hold_c6_ist", 64'(i_stall), 64'd1); chk("hold_c6_req", 64'(mem_req), 64'd0);
    nxt(); @(negedge clk); chk("hold_c7_req", 64'(mem_req), 64'd1);
    nxt(); @(negedge clk); chk("hold_c8_ird", 64'(i_rdata), 64'h5A5A_004C);
    nxt(); i_req = 1'b0;

    // Ready in the last allowed wait cycle: no error
    nxt(); d_req = 1'b1; d_addr = 32'h304; mem_lat = 4;
    push_mem(32'h304, 1'b0, 32'h0); exp_d.push_back(32'h5A5A_0304);
    st_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) nxt();
      @(negedge clk);
      if (d_stall) st_cnt++;
    end
    chk("lw4_stall_cycles", 64'(st_cnt), 64'd5);
    chk("lw4_bus_err", 64'(bus_err), 64'd0);
    chk("lw4_drd", 64'(d_rdata), 64'h5A5A_0304);
    nxt(); d_req = 1'b0;

    // Timeout on a load
    nxt(); d_req = 1'b1; d_addr = 32'h300; mem_lat = 0;
    push_mem(32'h300, 1'b0, 32'h0); exp_d.push_back(32'h0);
    nxt(); nxt(); nxt(); nxt();
    @(negedge clk); chk("to_c4_req", 64'(mem_req), 64'd1); chk("to_c4_err", 64'(bus_err), 64'd0);
    nxt(); @(negedge clk);
    chk("to_c5_dst", 64'(d_stall), 64'd0); chk("to_c5_drd", 64'(d_rdata), 64'd0);
    chk("to_c5_err", 64'(bus_err), 64'd1); chk("to_c5_req", 64'(mem_req), 64'd0);
    nxt(); d_req = 1'b0;
    nxt(); nxt(); @(negedge clk); chk("to_sticky", 64'(bus_err), 64'd1);

    // Next access proceeds normally
    nxt(); i_req = 1'b1; i_addr = 32'h50; mem_lat = 2;
    push_mem(32'h50, 1'b0, 32'h0); exp_i.push_back(32'h5A5A_0050);
    st_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) nxt();
      @(negedge clk);
      if (i_stall) st_cnt++;
    end
    chk("post_to_stalls", 64'(st_cnt), 64'd3);
    chk("post_to_err", 64'(bus_err), 64'd1);
    nxt(); i_req = 1'b0;

    // Reset in the middle of D_WAIT
    nxt(); d_req = 1'b1; d_addr = 32'h400; mem_lat = 0;
    push_mem(32'h400, 1'b0, 32'h0); push_mem(32'h400, 1'b0, 32'h0);
    exp_d.push_back(32'h5A5A_0400);
    nxt(); @(negedge clk); chk("mr_c1_req", 64'(mem_req), 64'd1);
    nxt(); reset_n = 1'b0;
    nxt(); @(negedge clk);
    chk("mr_c3_req", 64'(mem_req), 64'd0); chk("mr_c3_err", 64'(bus_err), 64'd0);
    chk("mr_c3_drd", 64'(d_rdata), 64'd0); chk("mr_c3_ird", 64'(i_rdata), 64'd0);
    chk("mr_c3_addr", 64'(mem_addr), 64'd0); chk("mr_c3_wd", 64'(mem_wdata), 64'd0);
    chk("mr_c3_we", 64'(mem_we), 64'd0); chk("mr_c3_dst", 64'(d_stall), 64'd1);
    nxt(); reset_n = 1'b1; mem_lat = 1;
    @(negedge clk); chk("mr_c4_req", 64'(mem_req), 64'd0);
    nxt(); @(negedge clk); chk("mr_c5_req", 64'(mem_req), 64'd1);
    nxt(); @(negedge clk); chk("mr_c6_dst", 64'(d_stall), 64'd0); chk("mr_c6_drd", 64'(d_rdata), 64'h5A5A_0400);
    nxt(); d_req = 1'b0;
    nxt(); nxt();
    @(negedge clk);

    chk("sb_mem_drained", 64'(exp_mem.size()), 64'd0);
    chk("sb_d_drained", 64'(exp_d.size()), 64'd0);
    chk("sb_i_drained", 64'(exp_i.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
